time_manage_multi: RTL and testbench

Trigger-gated, multi-channel period generator; parametrised successor of the single-channel 25 ms timer. Sits on the 100 MHz system clock next to the VPX/GPIO start trigger. After a configurable hold-off it emits NUM_CH independent periodic tick pulses with runtime-programmable periods. Supports continuous operation or a finite burst of ticks.

---
 rtl/time_manage_pkg.sv | 27 ++
 rtl/time_period_chan.sv | 61 ++++++
 rtl/time_manage_multi.sv | 219 +++++++++++++++++++++
 tb/tb_time_manage_multi.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/time_manage_pkg.sv
// -----------------------------------------------------------------------------
// time_manage_pkg
//
// Shared definitions for the trigger-gated period generator family.
//   - state_e      : FSM state encoding (2 bits)
//   - CLK_FREQ_HZ  : system clock frequency the timers are specified against
//   - PERIOD_25MS  : clocks in 25 ms at CLK_FREQ_HZ (legacy single-channel period)
//   - ms_to_clks() : helper turning a millisecond figure into a clock count
// -----------------------------------------------------------------------------
package time_manage_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLDOFF = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam int unsigned CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned PERIOD_25MS = 2_500_000;

    // Convenience for software-facing config tables; not used by the datapath.
    function automatic int unsigned ms_to_clks(input int unsigned ms);
        return ms * (CLK_FREQ_HZ / 1000);
    endfunction

endpackage

// File: rtl/time_period_chan.sv
// -----------------------------------------------------------------------------
// time_period_chan
//
// One periodic tick channel. While run is high the counter steps 0..P-1 and
// wraps; the cycle after each wrap tick is high for one clock. P = 0 disables
// the channel. Dropping run clears the counter and suppresses any pending tick.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active high
//   run     in   channel enable; low clears the channel
//   period  in   CNT_W period in clocks (0 = disabled)
//   tick    out  registered one-cycle tick
//   wrap    out  combinational: tick will be high next cycle
// -----------------------------------------------------------------------------
module time_period_chan #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    output logic             tick,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             enabled;
    logic             at_end;

    always_comb begin
        enabled = (period != '0);
        at_end  = (cnt_q == (period - CntOne));
        wrap    = run && enabled && at_end;
        tick_d  = wrap;
        cnt_d   = cnt_q;
        if (!run || !enabled) begin
            cnt_d = '0;
        end else if (at_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/time_manage_multi.sv
// -----------------------------------------------------------------------------
// time_manage_multi
//
// Trigger-gated multi-channel period generator. A level trigger is
// synchronised, then after a hold-off of max(holdoff,1) clocks NUM_CH channels
// emit periodic one-cycle ticks. Config is captured when leaving idle and is
// ignored until the next idle. A non-zero burst length stops the run after
// that many ch0 ticks; dropping the trigger aborts at any point.
//
// Ports:
//   sys_clk_i             in   system clock (100 MHz)
//   rst_i                 in   synchronous reset, active high
//   gpio_start_trigger_i  in   asynchronous start/enable level
//   holdoff_cfg_i         in   hold-off length in clocks
//   period_cfg_i          in   per-channel periods, ch k at [k*CNT_W +: CNT_W]
//   burst_len_i           in   ch0 ticks per run, 0 = continuous
//   holdoff_o             out  high during hold-off
//   tick_o                out  one-cycle tick per channel
//   running_o             out  high while running
//   done_o                out  high after a burst completes, until trigger drops
//   tick_cnt_o            out  saturating ch0 tick count since run start
// -----------------------------------------------------------------------------
module time_manage_multi
    import time_manage_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned BURST_W     = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    sys_clk_i,
    input  logic                    rst_i,
    input  logic                    gpio_start_trigger_i,
    input  logic [CNT_W-1:0]        holdoff_cfg_i,
    input  logic [NUM_CH*CNT_W-1:0] period_cfg_i,
    input  logic [BURST_W-1:0]      burst_len_i,
    output logic                    holdoff_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic                    running_o,
    output logic                    done_o,
    output logic [BURST_W-1:0]      tick_cnt_o
);

    localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);
    localparam logic [BURST_W-1:0] BurstOne = BURST_W'(1);

    // ------------------------------------------------------------------------
    // Trigger synchroniser (level only)
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_s;

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_start_trigger_i};
        end
    end

    assign trig_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_e state_q, state_d;

    logic [CNT_W-1:0]        holdoff_sh_q;
    logic [NUM_CH*CNT_W-1:0] period_sh_q;
    logic [BURST_W-1:0]      burst_sh_q;

    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   hold_end;
    logic               hold_last;
    logic [BURST_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [BURST_W-1:0] tick_cnt_inc;
    logic               burst_hit;
    logic               start;
    logic               chan_run;
    logic [NUM_CH-1:0]  wrap;
    logic [NUM_CH-1:0]  tick;
    logic               unused_wrap;

    // ------------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------------
    always_comb begin
        start        = (state_q == S_IDLE) && trig_s;
        // A zero hold-off still spends one cycle in S_HOLDOFF.
        hold_end     = (holdoff_sh_q == '0) ? '0 : (holdoff_sh_q - CntOne);
        hold_last    = (hold_cnt_q == hold_end);
        // Channels run only while staying in S_RUN; a trigger drop on this
        // edge therefore suppresses ticks due on the following cycle.
        chan_run     = (state_q == S_RUN) && trig_s;
        tick_cnt_inc = (tick_cnt_q == '1) ? tick_cnt_q : (tick_cnt_q + BurstOne);
        // wrap[0] means ch0 ticks next cycle; finish the burst on that edge so
        // done_o rises together with the final tick.
        burst_hit    = wrap[0] && (burst_sh_q != '0) && (tick_cnt_inc == burst_sh_q);
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (trig_s) begin
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (!trig_s) begin
                    state_d = S_IDLE;
                end else if (hold_last) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!trig_s) begin
                    state_d = S_IDLE;
                end else if (burst_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!trig_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        holdoff_o  = (state_q == S_HOLDOFF);
        running_o  = (state_q == S_RUN);
        done_o     = (state_q == S_DONE);
        tick_o     = tick;
        tick_cnt_o = tick_cnt_q;
    end

    // ------------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------------
    always_comb begin
        if ((state_q == S_HOLDOFF) && trig_s && !hold_last) begin
            hold_cnt_d = hold_cnt_q + CntOne;
        end else begin
            hold_cnt_d = '0;
        end

        tick_cnt_d = tick_cnt_q;
        if (start) begin
            tick_cnt_d = '0;
        end else if (wrap[0]) begin
            tick_cnt_d = tick_cnt_inc;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            hold_cnt_q <= '0;
            tick_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Shadow config, captured only when a run starts
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            holdoff_sh_q <= '0;
            period_sh_q  <= '0;
            burst_sh_q   <= '0;
        end else if (start) begin
            holdoff_sh_q <= holdoff_cfg_i;
            period_sh_q  <= period_cfg_i;
            burst_sh_q   <= burst_len_i;
        end
    end

    // ------------------------------------------------------------------------
    // Tick channels
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        time_period_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk    (sys_clk_i),
            .rst    (rst_i),
            .run    (chan_run),
            .period (period_sh_q[k*CNT_W +: CNT_W]),
            .tick   (tick[k]),
            .wrap   (wrap[k])
        );
    end

    // Only ch0's wrap drives the burst logic.
    assign unused_wrap = ^wrap;

endmodule

// File: tb/tb_time_manage_multi.sv
// -----------------------------------------------------------------------------
// tb_time_manage_multi
//
// Directed scenarios followed by randomized trigger/config sequences. Every
// cycle the DUT outputs are compared with a timestamp-based reference model.
// -----------------------------------------------------------------------------
module tb_time_manage_multi;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned BURST_W     = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          MAXC        = 16384;
    localparam int          TCNT_MAX    = (1 << BURST_W) - 1;

    logic                    sys_clk_i = 1'b0;
    logic                    rst_i;
    logic                    gpio_start_trigger_i;
    logic [CNT_W-1:0]        holdoff_cfg_i;
    logic [NUM_CH*CNT_W-1:0] period_cfg_i;
    logic [BURST_W-1:0]      burst_len_i;
    logic                    holdoff_o;
    logic [NUM_CH-1:0]       tick_o;
    logic                    running_o;
    logic                    done_o;
    logic [BURST_W-1:0]      tick_cnt_o;

    always #5 sys_clk_i = ~sys_clk_i;

    time_manage_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .BURST_W     (BURST_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .sys_clk_i            (sys_clk_i),
        .rst_i                (rst_i),
        .gpio_start_trigger_i (gpio_start_trigger_i),
        .holdoff_cfg_i        (holdoff_cfg_i),
        .period_cfg_i         (period_cfg_i),
        .burst_len_i          (burst_len_i),
        .holdoff_o            (holdoff_o),
        .tick_o               (tick_o),
        .running_o            (running_o),
        .done_o               (done_o),
        .tick_cnt_o           (tick_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: run phases described by start timestamps
    // ------------------------------------------------------------------------
    typedef enum {MIdle, MHold, MRun, MDone} mmode_e;

    mmode_e            m_mode = MIdle;
    bit                trig_hist [MAXC];
    int                rst_cyc = 0;
    int                m_hs, m_t0, m_h, m_b, m_tcnt;
    int                m_p [NUM_CH];
    logic [NUM_CH-1:0] m_tick;

    // Advance the model to cycle cyc using the inputs seen at the edge.
    task automatic model_update();
        int c1;
        bit ts;
        m_tick = '0;
        if (rst_i) begin
            m_mode  = MIdle;
            m_tcnt  = 0;
            rst_cyc = cyc;
            return;
        end
        c1 = cyc - 1;
        // Trigger level reaches the FSM SYNC_STAGES cycles after it is driven.
        ts = (c1 - int'(SYNC_STAGES) >= rst_cyc) ? trig_hist[c1 - int'(SYNC_STAGES)] : 1'b0;
        case (m_mode)
            MIdle: begin
                if (ts) begin
                    m_mode = MHold;
                    m_hs   = cyc;
                    m_h    = (holdoff_cfg_i == 0) ? 1 : int'(holdoff_cfg_i);
                    m_b    = int'(burst_len_i);
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        m_p[k] = int'(period_cfg_i[k*CNT_W +: CNT_W]);
                    end
                    m_tcnt = 0;
                end
            end
            MHold: begin
                if (!ts) begin
                    m_mode = MIdle;
                end else if (cyc - m_hs == m_h) begin
                    m_mode = MRun;
                    m_t0   = cyc;
                end
            end
            MRun: begin
                if (!ts) begin
                    m_mode = MIdle;
                end else begin
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        if (m_p[k] > 0 && ((cyc - m_t0) % m_p[k]) == 0) m_tick[k] = 1'b1;
                    end
                    if (m_tick[0]) begin
                        if (m_tcnt < TCNT_MAX) m_tcnt++;
                        if (m_b != 0 && m_tcnt == m_b) m_mode = MDone;
                    end
                end
            end
            MDone: begin
                if (!ts) m_mode = MIdle;
            end
            default: m_mode = MIdle;
        endcase
    endtask

    task automatic step();
        @(posedge sys_clk_i);
        if (cyc >= MAXC - 2) begin
            $display("FAIL cycle_budget cycle=%0d got=overflow expected=<%0d", cyc, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        trig_hist[cyc] = gpio_start_trigger_i;
        cyc++;
        model_update();
        #1;
        check_eq("holdoff_o", 32'(holdoff_o), 32'(m_mode == MHold));
        check_eq("running_o", 32'(running_o), 32'(m_mode == MRun));
        check_eq("done_o", 32'(done_o), 32'(m_mode == MDone));
        check_eq("tick_o", 32'(tick_o), 32'(m_tick));
        check_eq("tick_cnt_o", 32'(tick_cnt_o), 32'(m_tcnt));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_cfg(input int h, input int p0, input int p1, input int b);
        holdoff_cfg_i = CNT_W'(h);
        period_cfg_i  = {CNT_W'(p1), CNT_W'(p0)};
        burst_len_i   = BURST_W'(b);
    endtask

    task automatic set_cfg_rand();
        set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 9)),
                ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 5)));
    endtask

    initial begin
        rst_i                = 1'b1;
        gpio_start_trigger_i = 1'b0;
        set_cfg(5, 4, 3, 0);
        steps(3);
        rst_i = 1'b0;
        steps(7);

        // Basic continuous run, trigger raised at cycle 10
        gpio_start_trigger_i = 1'b1;
        steps(50);
        gpio_start_trigger_i = 1'b0;
        steps(8);

        // Burst of 3 with ch1 disabled
        set_cfg(2, 4, 0, 3);
        gpio_start_trigger_i = 1'b1;
        steps(40);
        gpio_start_trigger_i = 1'b0;
        steps(6);

        // Trigger drop landing on the 2nd ch0 tick
        set_cfg(1, 4, 4, 0);
        gpio_start_trigger_i = 1'b1;
        steps(9);
        gpio_start_trigger_i = 1'b0;
        steps(8);

        // Config change mid-run is ignored until restart
        set_cfg(0, 4, 4, 0);
        gpio_start_trigger_i = 1'b1;
        steps(20);
        set_cfg(0, 7, 7, 0);
        steps(20);
        gpio_start_trigger_i = 1'b0;
        steps(5);
        gpio_start_trigger_i = 1'b1;
        steps(30);
        gpio_start_trigger_i = 1'b0;
        steps(5);

        // Period 1 with tick counter saturation
        set_cfg(0, 1, 2, 0);
        gpio_start_trigger_i = 1'b1;
        steps(30);
        gpio_start_trigger_i = 1'b0;
        steps(5);

        // Burst with ch0 disabled never completes; burst of 1
        set_cfg(0, 0, 3, 2);
        gpio_start_trigger_i = 1'b1;
        steps(25);
        gpio_start_trigger_i = 1'b0;
        steps(4);
        set_cfg(3, 5, 2, 1);
        gpio_start_trigger_i = 1'b1;
        steps(20);
        gpio_start_trigger_i = 1'b0;
        steps(4);

        // Reset pulse mid-run with the trigger held
        set_cfg(3, 3, 5, 0);
        gpio_start_trigger_i = 1'b1;
        steps(15);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        steps(25);
        gpio_start_trigger_i = 1'b0;
        steps(5);

        // Randomized runs with mid-run config noise and rare resets
        for (int it = 0; it < 60; it++) begin
            int hi;
            set_cfg_rand();
            gpio_start_trigger_i = 1'b1;
            hi = int'($urandom_range(1, 60));
            for (int i = 0; i < hi; i++) begin
                if ($urandom_range(0, 15) == 0) set_cfg_rand();
                if ($urandom_range(0, 199) == 0) rst_i = 1'b1;
                step();
                rst_i = 1'b0;
            end
            gpio_start_trigger_i = 1'b0;
            steps(int'($urandom_range(1, 6)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
